// File: rtl/otl_bus_router.sv
// One-master to NSLV-slave router for the otl register bus: a registered write
// slice plus a single-outstanding read FSM with error responses and timeout.
module otl_bus_router #(
    parameter int                      ADDRW   = 32,
    parameter int                      DATAW   = 32,
    parameter int                      NSLV    = 3,
    parameter int                      SELLO   = 12,
    parameter int                      SELW    = 4,
    parameter logic [NSLV*SELW-1:0]    SLV_MAP = {4'h2, 4'h1, 4'h0},
    parameter int                      TOUT    = 256,
    parameter logic [DATAW-1:0]        ERRDATA = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATAW-1:0]        s_wrdata,
    input  logic [ADDRW-1:0]        s_wraddr,
    input  logic                    s_wrvalid,
    output logic                    s_wrready,
    output logic                    s_wrerr,
    input  logic [ADDRW-1:0]        s_rdaddr,
    input  logic                    s_rdreq,
    output logic                    s_rdack,
    output logic [DATAW-1:0]        s_rddata,
    output logic                    s_rdvalid,
    input  logic                    s_rdready,
    output logic                    s_rderr,
    output logic [DATAW-1:0]        m_wrdata,
    output logic [ADDRW-1:0]        m_wraddr,
    output logic [NSLV-1:0]         m_wrvalid,
    input  logic [NSLV-1:0]         m_wrready,
    output logic [ADDRW-1:0]        m_rdaddr,
    output logic [NSLV-1:0]         m_rdreq,
    input  logic [NSLV-1:0]         m_rdack,
    input  logic [NSLV*DATAW-1:0]   m_rddata,
    input  logic [NSLV-1:0]         m_rdvalid,
    output logic [NSLV-1:0]         m_rdready
);

    localparam int IW      = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int TW      = (TOUT > 1) ? $clog2(TOUT) : 1;
    localparam int TOUT_M1 = (TOUT > 0) ? TOUT - 1 : 0;
    localparam logic [TW-1:0] TLAST = TW'(TOUT_M1);

    // Returns {unmapped, index}; scanning downwards lets the lowest index win.
    function automatic logic [IW:0] decode(input logic [ADDRW-1:0] addr);
        logic [IW:0] res;
        res = {1'b1, {IW{1'b0}}};
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (addr[SELLO +: SELW] == SLV_MAP[i*SELW +: SELW])
                res = {1'b0, IW'(i)};
        end
        return res;
    endfunction

    logic              wr_full;
    logic              wr_unm;
    logic [IW-1:0]     wr_idx;
    logic [ADDRW-1:0]  wr_addr;
    logic [DATAW-1:0]  wr_data;
    logic [IW:0]       wr_dec;
    logic              wr_drain;
    logic              wr_acc;

    assign wr_dec    = decode(s_wraddr);
    assign wr_drain  = wr_full & (wr_unm | m_wrready[wr_idx]);
    assign s_wrready = ~wr_full | wr_drain;
    assign wr_acc    = s_wrvalid & s_wrready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_full <= 1'b0;
            wr_unm  <= 1'b0;
            wr_idx  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (wr_acc) begin
            wr_full <= 1'b1;
            wr_unm  <= wr_dec[IW];
            wr_idx  <= wr_dec[IW-1:0];
            wr_addr <= s_wraddr;
            wr_data <= s_wrdata;
        end else if (wr_drain) begin
            wr_full <= 1'b0;
        end
    end

    // An unmapped entry drains unconditionally, so this is a single-cycle pulse.
    assign s_wrerr  = wr_full & wr_unm;
    assign m_wrdata = wr_data;
    assign m_wraddr = wr_addr;

    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT, RD_RESP} rd_state_t;

    rd_state_t         rd_state;
    logic [ADDRW-1:0]  rd_addr;
    logic [IW-1:0]     rd_idx;
    logic [DATAW-1:0]  rd_data;
    logic              rd_err;
    logic [TW-1:0]     rd_cnt;
    logic [IW:0]       rd_dec;
    logic              rd_expire;

    assign rd_dec    = decode(s_rdaddr);
    assign rd_expire = (TOUT != 0) && (rd_cnt == TLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_idx   <= '0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
            rd_cnt   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (s_rdreq) begin
                        rd_addr <= s_rdaddr;
                        rd_idx  <= rd_dec[IW-1:0];
                        rd_cnt  <= '0;
                        if (rd_dec[IW]) begin
                            rd_err   <= 1'b1;
                            rd_data  <= ERRDATA;
                            rd_state <= RD_RESP;
                        end else begin
                            rd_state <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (m_rdack[rd_idx]) begin
                        rd_cnt   <= rd_cnt + TW'(1);
                        rd_state <= RD_WAIT;
                    end else if (rd_expire) begin
                        rd_err   <= 1'b1;
                        rd_data  <= ERRDATA;
                        rd_state <= RD_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + TW'(1);
                    end
                end
                RD_WAIT: begin
                    if (m_rdvalid[rd_idx]) begin
                        rd_err   <= 1'b0;
                        rd_data  <= m_rddata[rd_idx*DATAW +: DATAW];
                        rd_state <= RD_RESP;
                    end else if (rd_expire) begin
                        rd_err   <= 1'b1;
                        rd_data  <= ERRDATA;
                        rd_state <= RD_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + TW'(1);
                    end
                end
                RD_RESP: begin
                    if (s_rdready)
                        rd_state <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s_rdack   = (rd_state == RD_IDLE);
    assign s_rdvalid = (rd_state == RD_RESP);
    assign s_rddata  = rd_data;
    assign s_rderr   = rd_err;
    assign m_rdaddr  = rd_addr;

    always_comb begin
        m_wrvalid = '0;
        m_rdreq   = '0;
        m_rdready = '0;
        for (int i = 0; i < NSLV; i++) begin
            m_wrvalid[i] = wr_full & ~wr_unm & (wr_idx == IW'(i));
            m_rdreq[i]   = (rd_state == RD_REQ)  & (rd_idx == IW'(i));
            m_rdready[i] = (rd_state == RD_WAIT) & (rd_idx == IW'(i));
        end
    end

endmodule

// File: tb/tb_otl_bus_router.sv
// Bench for otl_bus_router: reactive slave models, a queue scoreboard fed at
// master-side accepts and drained by a monitor, directed cases then random traffic.
module tb_otl_bus_router;

    localparam int N    = 3;
    localparam int TOUT = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic            clk;
    logic            rst;
    logic [31:0]     s_wrdata, s_wraddr, s_rdaddr, s_rddata;
    logic            s_wrvalid, s_wrready, s_wrerr;
    logic            s_rdreq, s_rdack, s_rdvalid, s_rdready, s_rderr;
    logic [31:0]     m_wrdata, m_wraddr, m_rdaddr;
    logic [N-1:0]    m_wrvalid, m_wrready, m_rdreq, m_rdack, m_rdvalid, m_rdready;
    logic [N*32-1:0] m_rddata;

    otl_bus_router #(.TOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .s_wrdata(s_wrdata), .s_wraddr(s_wraddr), .s_wrvalid(s_wrvalid),
        .s_wrready(s_wrready), .s_wrerr(s_wrerr),
        .s_rdaddr(s_rdaddr), .s_rdreq(s_rdreq), .s_rdack(s_rdack),
        .s_rddata(s_rddata), .s_rdvalid(s_rdvalid), .s_rdready(s_rdready), .s_rderr(s_rderr),
        .m_wrdata(m_wrdata), .m_wraddr(m_wraddr), .m_wrvalid(m_wrvalid), .m_wrready(m_wrready),
        .m_rdaddr(m_rdaddr), .m_rdreq(m_rdreq), .m_rdack(m_rdack),
        .m_rddata(m_rddata), .m_rdvalid(m_rdvalid), .m_rdready(m_rdready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { int slv; logic [31:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct packed { logic [31:0] data; logic err; } rd_exp_t;
    wr_exp_t wq[$];
    rd_exp_t rq[$];

    int n_vec = 0;
    int n_err = 0;

    // Environment knobs
    logic        dead0 = 1'b0;
    int          ack_lat = 0;
    int          dat_lat = 0;
    logic        wr_rand = 1'b0;
    logic [N-1:0] wr_mask = '1;
    logic        rd_rand = 1'b0;
    logic        rd_rdy_val = 1'b1;
    logic        rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = 32'h0;
    logic        wr_acc_seen = 1'b0;
    logic        rd_acc_seen = 1'b0;

    logic [31:0] b2b_addr [3];
    logic [N-1:0] b2b_exp [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference address map: select field addr[15:12] equal to i selects slave i.
    function automatic int exp_slave(input logic [31:0] a);
        return (a[15:12] < 4'd3) ? int'(a[15:12]) : -1;
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a, input int i);
        return rd_fixed_en ? rd_fixed : ((a ^ 32'h5A5A_0000) + 32'(i) * 32'h0101_0101);
    endfunction

    // Slave models plus the master's response-ready driver
    int          req_age [N];
    int          data_age [N];
    logic        pend [N];
    logic [31:0] paddr [N];

    initial begin
        m_wrready = '0; m_rdack = '0; m_rdvalid = '0; m_rddata = '0; s_rdready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_age[i] = 0; data_age[i] = 0; pend[i] = 1'b0; paddr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    pend[i] = 1'b0;
                    req_age[i] = 0;
                end else begin
                    if (m_rdreq[i] && m_rdack[i]) begin
                        pend[i] = 1'b1; paddr[i] = m_rdaddr; data_age[i] = 0;
                    end else if (pend[i] && m_rdvalid[i] && m_rdready[i]) begin
                        pend[i] = 1'b0;
                    end else if (pend[i]) begin
                        data_age[i]++;
                    end
                    req_age[i] = (m_rdreq[i] && !m_rdack[i]) ? req_age[i] + 1 : 0;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                m_rdack[i]   = !(dead0 && i == 0) && (req_age[i] >= ack_lat);
                m_rdvalid[i] = pend[i] && (data_age[i] >= dat_lat);
                m_rddata[i*32 +: 32] = pend[i] ? slave_data(paddr[i], i) : $urandom;
            end
            m_wrready = (wr_rand ? N'($urandom) : N'('1)) & wr_mask;
            s_rdready = rd_rand ? 1'($urandom) : rd_rdy_val;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_exp_t we;
        rd_exp_t re;
        int      s;
        if (rst) begin
            wr_acc_seen = 1'b0;
            rd_acc_seen = 1'b0;
        end else begin
            check("onehot", ($countones(m_wrvalid) <= 1) && ($countones(m_rdreq) <= 1)
                            && ($countones(m_rdready) <= 1), 1);
            if (s_wrerr) begin
                check("wrerr_expected", (wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    we = wq.pop_front();
                    check("wrerr_slot_unmapped", we.slv, -1);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_wrvalid[i] && m_wrready[i]) begin
                    check("wr_expected", (wq.size() != 0), 1);
                    if (wq.size() != 0) begin
                        we = wq.pop_front();
                        check("wr_slave", i, we.slv);
                        check("wr_addr", m_wraddr, we.addr);
                        check("wr_data", m_wrdata, we.data);
                    end
                end
            end
            if (s_rdvalid && s_rdready) begin
                check("rd_expected", (rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    re = rq.pop_front();
                    check("rd_data", s_rddata, re.data);
                    check("rd_err", s_rderr, re.err);
                end
            end
            wr_acc_seen = s_wrvalid && s_wrready;
            rd_acc_seen = s_rdreq && s_rdack;
            if (wr_acc_seen) begin
                we.slv = exp_slave(s_wraddr); we.addr = s_wraddr; we.data = s_wrdata;
                wq.push_back(we);
            end
            if (rd_acc_seen) begin
                s = exp_slave(s_rdaddr);
                if (s < 0 || (s == 0 && dead0)) begin
                    re.data = ERRD; re.err = 1'b1;
                end else begin
                    re.data = slave_data(s_rdaddr, s); re.err = 1'b0;
                end
                rq.push_back(re);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!s_rdvalid && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (!s_rdvalid) check("rdvalid_within_bound", s_rdvalid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc_cnt;
        int g;
        logic spurious;
        rst = 1'b1;
        s_wrvalid = 1'b0; s_wraddr = '0; s_wrdata = '0;
        s_rdreq = 1'b0; s_rdaddr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_s_wrready", s_wrready, 1);
        check("rst_s_rdack", s_rdack, 1);
        check("rst_s_rdvalid", s_rdvalid, 0);
        check("rst_s_wrerr", s_wrerr, 0);
        check("rst_s_rderr", s_rderr, 0);
        check("rst_m_wrvalid", m_wrvalid, 0);
        check("rst_m_rdreq", m_rdreq, 0);
        check("rst_m_rdready", m_rdready, 0);

        // Single write, latency 1
        cyc();
        s_wrvalid = 1'b1; s_wraddr = 32'h0000_1004; s_wrdata = 32'h55;
        @(negedge clk);
        check("wr1_ready", s_wrready, 1);
        cyc();
        s_wrvalid = 1'b0;
        @(negedge clk);
        check("wr1_m_wrvalid", m_wrvalid, 3'b010);
        check("wr1_m_wraddr", m_wraddr, 32'h0000_1004);
        check("wr1_m_wrdata", m_wrdata, 32'h55);

        // Back-to-back writes to slaves 0,2,0
        b2b_addr[0] = 32'h0000_0100; b2b_addr[1] = 32'h0000_2200; b2b_addr[2] = 32'h0000_0300;
        b2b_exp[0] = 3'b001; b2b_exp[1] = 3'b100; b2b_exp[2] = 3'b001;
        cyc();
        for (int k = 0; k < 3; k++) begin
            s_wrvalid = 1'b1; s_wraddr = b2b_addr[k]; s_wrdata = 32'h100 + k;
            @(negedge clk);
            check("b2b_ready", s_wrready, 1);
            if (k > 0) check("b2b_valid", m_wrvalid, b2b_exp[k-1]);
            cyc();
        end
        s_wrvalid = 1'b0;
        @(negedge clk);
        check("b2b_valid_last", m_wrvalid, b2b_exp[2]);

        // Stall slave 2 for 5 cycles
        wr_mask = 3'b011;
        cyc();
        s_wrvalid = 1'b1; s_wraddr = 32'h0000_2040; s_wrdata = 32'hA1;
        cyc();
        s_wraddr = 32'h0000_0050; s_wrdata = 32'hA2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ready", s_wrready, 0);
            check("stall_valid", m_wrvalid, 3'b100);
            check("stall_addr", m_wraddr, 32'h0000_2040);
            check("stall_data", m_wrdata, 32'hA1);
        end
        wr_mask = 3'b111;
        cyc();
        cyc();
        s_wrvalid = 1'b0;

        // Unmapped write
        cyc();
        s_wrvalid = 1'b1; s_wraddr = 32'h0000_7000; s_wrdata = 32'h77;
        cyc();
        s_wrvalid = 1'b0;
        @(negedge clk);
        check("unm_wrerr", s_wrerr, 1);
        check("unm_no_wrvalid", m_wrvalid, 0);
        check("unm_ready", s_wrready, 1);
        @(negedge clk);
        check("unm_wrerr_pulse", s_wrerr, 0);
        check("unm_ready_next", s_wrready, 1);

        // Read slave 2 with delayed ack/data and held response
        ack_lat = 2; dat_lat = 3; rd_fixed_en = 1'b1; rd_fixed = 32'h0000_CAFE; rd_rdy_val = 1'b0;
        cyc();
        s_rdreq = 1'b1; s_rdaddr = 32'h0000_2010;
        @(negedge clk);
        check("rd_ack_idle", s_rdack, 1);
        cyc();
        s_rdreq = 1'b0;
        wait_rv(cyc_cnt);
        check("rd_cafe_data", s_rddata, 32'h0000_CAFE);
        check("rd_cafe_err", s_rderr, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rd_hold_valid", s_rdvalid, 1);
            check("rd_hold_data", s_rddata, 32'h0000_CAFE);
            check("rd_hold_noack", s_rdack, 0);
        end
        rd_rdy_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rd_back_idle", s_rdack, 1);
        check("rd_resp_done", s_rdvalid, 0);

        // Timeout on slave 0, then unmapped read
        rd_fixed_en = 1'b0; dead0 = 1'b1; ack_lat = 0; dat_lat = 0;
        cyc();
        s_rdreq = 1'b1; s_rdaddr = 32'h0000_0000;
        cyc();
        s_rdreq = 1'b0;
        wait_rv(cyc_cnt);
        check("tout_latency", cyc_cnt, TOUT);
        check("tout_data", s_rddata, ERRD);
        check("tout_err", s_rderr, 1);
        @(negedge clk);
        cyc();
        s_rdreq = 1'b1; s_rdaddr = 32'h0000_F000;
        cyc();
        s_rdreq = 1'b0;
        wait_rv(cyc_cnt);
        check("unm_rd_next_cycle", cyc_cnt + 1, 1);
        check("unm_rd_data", s_rddata, ERRD);
        check("unm_rd_err", s_rderr, 1);
        @(negedge clk);
        dead0 = 1'b0;

        // Reset during read WAIT with the write slice stalled
        wr_mask = 3'b011; dat_lat = 20;
        cyc();
        s_wrvalid = 1'b1; s_wraddr = 32'h0000_2100; s_wrdata = 32'h99;
        s_rdreq = 1'b1; s_rdaddr = 32'h0000_1010;
        cyc();
        s_wrvalid = 1'b0; s_rdreq = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_rdready", m_rdready, 3'b010);
        check("pre_rst_wrvalid", m_wrvalid, 3'b100);
        cyc();
        rst = 1'b1;
        wq.delete();
        rq.delete();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_wrvalid", m_wrvalid, 0);
        check("mid_rst_rdreq", m_rdreq, 0);
        check("mid_rst_rdready", m_rdready, 0);
        check("mid_rst_rdack", s_rdack, 1);
        check("mid_rst_wrready", s_wrready, 1);
        check("mid_rst_rdvalid", s_rdvalid, 0);
        wr_mask = 3'b111;
        spurious = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (s_rdvalid || s_wrerr || (m_wrvalid != 0)) spurious = 1'b1;
        end
        check("no_resp_after_rst", spurious, 0);

        // Random concurrent traffic
        wr_rand = 1'b1; rd_rand = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    cyc();
                    if (!s_wrvalid || wr_acc_seen) begin
                        s_wrvalid = ($urandom_range(0, 3) != 0);
                        s_wraddr  = {16'h0, 4'($urandom_range(0, 4)), 12'($urandom)};
                        s_wrdata  = $urandom;
                    end
                end
                g = 0;
                while (s_wrvalid && g < 200) begin
                    cyc();
                    if (wr_acc_seen) s_wrvalid = 1'b0;
                    g++;
                end
                check("rand_wr_drained", s_wrvalid, 0);
            end
            begin
                int h;
                for (int n = 0; n < 60; n++) begin
                    ack_lat = $urandom_range(0, 4);
                    dat_lat = $urandom_range(0, 4);
                    s_rdaddr = {16'h0, 4'($urandom_range(0, 4)), 12'($urandom)};
                    if ($urandom_range(0, 9) == 0) s_rdaddr[15:12] = 4'hF;
                    s_rdreq = 1'b1;
                    h = 0;
                    do begin
                        cyc();
                        h++;
                    end while (!rd_acc_seen && h < 100);
                    s_rdreq = 1'b0;
                    h = 0;
                    while (rq.size() != 0 && h < 100) begin
                        cyc();
                        h++;
                    end
                    check("rand_rd_completed", (rq.size() == 0), 1);
                end
            end
        join
        repeat (10) cyc();
        check("final_wq_empty", wq.size(), 0);
        check("final_rq_empty", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
